// File: rtl/boot_loader.sv
// ============================================================================
// Module   : boot_loader
// Purpose  : Receives a program image byte stream, writes it word-by-word into
//            the unified RAM, then releases the core from reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_loader #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  input  logic [WIDTH-1:0] i_core_addr,
  input  logic [31:0]      i_core_data,
  input  logic             i_core_we,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [31:0]      o_mem_data,
  output logic             o_mem_we,
  output logic             o_core_rst_n,
  output logic             o_busy,
  output logic             o_error
);

  typedef enum logic [2:0] {
    S_CLO  = 3'd0,
    S_CHI  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam int unsigned c_words     = 2 ** (WIDTH - 2);
  localparam logic [16:0] c_max_words = 17'(c_words);

  state_t             r_state;
  state_t             w_next;
  logic [7:0]         r_cnt_lo;
  logic [15:0]        r_words_left;
  logic [1:0]         r_byte_cnt;
  logic [23:0]        r_word;
  logic [7:0]         r_csum;
  logic [WIDTH-3:0]   r_word_idx;
  logic               r_we;
  logic [WIDTH-1:0]   r_addr;
  logic [31:0]        r_data;
  logic               r_core_rst_n;

  logic               w_rx_ready;
  logic               w_busy;
  logic               w_error;
  logic               w_fire;
  logic [15:0]        w_count;
  logic               w_oversize;
  logic               w_last_byte;
  logic [7:0]         w_csum_next;
  logic               w_run;

  assign w_fire      = i_rx_valid & w_rx_ready;
  assign w_count     = {i_rx_data, r_cnt_lo};
  assign w_oversize  = ({1'b0, w_count} > c_max_words);
  assign w_last_byte = (r_byte_cnt == 2'd3);
  assign w_csum_next = r_csum ^ i_rx_data;
  assign w_run       = (r_state == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLO;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_rx_ready = 1'b0;
    w_busy     = 1'b1;
    w_error    = 1'b0;
    case (r_state)
      S_CLO: begin
        w_rx_ready = 1'b1;
        if (w_fire) w_next = S_CHI;
      end
      S_CHI: begin
        w_rx_ready = 1'b1;
        if (w_fire) begin
          if (w_oversize)            w_next = S_ERR;
          else if (w_count == 16'd0) w_next = S_CSUM;
          else                       w_next = S_DATA;
        end
      end
      S_DATA: begin
        w_rx_ready = 1'b1;
        if (w_fire && w_last_byte && (r_words_left == 16'd1)) w_next = S_CSUM;
      end
      S_CSUM: begin
        w_rx_ready = 1'b1;
        if (w_fire) w_next = (w_csum_next == 8'h00) ? S_RUN : S_ERR;
      end
      S_RUN: begin
        w_busy = 1'b0;
      end
      S_ERR: begin
        w_busy  = 1'b0;
        w_error = 1'b1;
      end
      default: begin
        w_next = S_CLO;
      end
    endcase
  end

  // Datapath: count capture, word assembly, checksum and the registered write pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_lo     <= 8'h00;
      r_words_left <= 16'h0000;
      r_byte_cnt   <= 2'd0;
      r_word       <= 24'h000000;
      r_csum       <= 8'h00;
      r_word_idx   <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= 32'h0000_0000;
    end else begin
      r_we <= 1'b0;
      if (w_fire) begin
        r_csum <= w_csum_next;
        case (r_state)
          S_CLO: begin
            r_cnt_lo <= i_rx_data;
          end
          S_CHI: begin
            if (!w_oversize) r_words_left <= w_count;
          end
          S_DATA: begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0: r_word[7:0]   <= i_rx_data;
              2'd1: r_word[15:8]  <= i_rx_data;
              2'd2: r_word[23:16] <= i_rx_data;
              default: begin
                r_we         <= 1'b1;
                r_addr       <= {r_word_idx, 2'b00};
                r_data       <= {i_rx_data, r_word};
                r_word_idx   <= r_word_idx + 1'b1;
                r_words_left <= r_words_left - 16'd1;
              end
            endcase
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Core reset releases one edge after RUN is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_core_rst_n <= 1'b0;
    end else begin
      r_core_rst_n <= w_run;
    end
  end

  assign o_mem_addr   = w_run ? i_core_addr : r_addr;
  assign o_mem_data   = w_run ? i_core_data : r_data;
  assign o_mem_we     = w_run ? i_core_we   : r_we;
  assign o_rx_ready   = w_rx_ready;
  assign o_core_rst_n = r_core_rst_n;
  assign o_busy       = w_busy;
  assign o_error      = w_error;

endmodule

`default_nettype wire

// File: tb/tb_boot_loader.sv
// ============================================================================
// Module   : tb_boot_loader
// Purpose  : Randomized self-checking bench for boot_loader against an
//            image-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boot_loader;

  localparam int WIDTH = 12;
  localparam int CAP   = 1 << (WIDTH - 2);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       i_rx_data = 8'h00;
  logic             i_rx_valid = 1'b0;
  logic             o_rx_ready;
  logic [WIDTH-1:0] i_core_addr = '0;
  logic [31:0]      i_core_data = 32'h0;
  logic             i_core_we = 1'b0;
  logic [WIDTH-1:0] o_mem_addr;
  logic [31:0]      o_mem_data;
  logic             o_mem_we;
  logic             o_core_rst_n;
  logic             o_busy;
  logic             o_error;

  boot_loader #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_rx_ready   (o_rx_ready),
    .i_core_addr  (i_core_addr),
    .i_core_data  (i_core_data),
    .i_core_we    (i_core_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_data   (o_mem_data),
    .o_mem_we     (o_mem_we),
    .o_core_rst_n (o_core_rst_n),
    .o_busy       (o_busy),
    .o_error      (o_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Image-level model: 0 = loading, 1 = running, 2 = rejected
  int          m_term;
  int          m_pos;
  int          m_n;
  logic [7:0]  m_lo;
  logic [7:0]  m_x;
  logic [31:0] m_acc;

  logic [31:0] g_words[$];
  logic [7:0]  g_img[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_term = 0;
    m_pos  = 0;
    m_n    = 0;
    m_lo   = 8'h00;
    m_x    = 8'h00;
    m_acc  = 32'h0;
  endtask

  // One clock: drive at negedge, update model at posedge, compare just after.
  task automatic cycle(input logic v, input logic [7:0] d);
    logic        acc;
    logic        exp_rst;
    logic        pend;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    @(negedge clk);
    i_rx_valid  = v;
    i_rx_data   = d;
    i_core_addr = WIDTH'($urandom);
    i_core_data = $urandom;
    i_core_we   = 1'($urandom);
    check("rx_ready", {31'h0, o_rx_ready}, {31'h0, m_term == 0});
    acc = v && (m_term == 0);
    @(posedge clk);
    exp_rst  = (m_term == 1);
    pend     = 1'b0;
    exp_addr = 32'h0;
    exp_data = 32'h0;
    if (acc) begin
      m_x = m_x ^ d;
      if (m_pos == 0) begin
        m_lo = d;
      end else if (m_pos == 1) begin
        m_n = int'({d, m_lo});
        if (m_n > CAP) m_term = 2;
      end else if (m_pos < 2 + 4 * m_n) begin
        m_acc = {d, m_acc[31:8]};
        if ((m_pos - 2) % 4 == 3) begin
          pend     = 1'b1;
          exp_data = m_acc;
          exp_addr = 32'(((m_pos - 2) / 4) * 4);
        end
      end else begin
        m_term = (m_x == 8'h00) ? 1 : 2;
      end
      m_pos++;
    end
    #1;
    check("busy", {31'h0, o_busy}, {31'h0, m_term == 0});
    check("error", {31'h0, o_error}, {31'h0, m_term == 2});
    check("core_rst_n", {31'h0, o_core_rst_n}, {31'h0, exp_rst});
    if (m_term == 1) begin
      check("pass_we", {31'h0, o_mem_we}, {31'h0, i_core_we});
      check("pass_addr", {20'h0, o_mem_addr}, {20'h0, i_core_addr});
      check("pass_data", o_mem_data, i_core_data);
    end else begin
      check("mem_we", {31'h0, o_mem_we}, {31'h0, pend});
      if (pend) begin
        check("mem_addr", {20'h0, o_mem_addr}, exp_addr);
        check("mem_data", o_mem_data, exp_data);
      end
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 8'($urandom));
  endtask

  // Asynchronous reset asserted away from any clock edge
  task automatic do_reset();
    @(negedge clk);
    i_rx_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_we", {31'h0, o_mem_we}, 32'h0);
    check("rst_addr", {20'h0, o_mem_addr}, 32'h0);
    check("rst_data", o_mem_data, 32'h0);
    check("rst_core_rst_n", {31'h0, o_core_rst_n}, 32'h0);
    check("rst_busy", {31'h0, o_busy}, 32'h1);
    check("rst_error", {31'h0, o_error}, 32'h0);
    check("rst_ready", {31'h0, o_rx_ready}, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic build(input logic [15:0] n16, input logic [7:0] bad);
    logic [7:0] x;
    g_img.delete();
    g_img.push_back(n16[7:0]);
    g_img.push_back(n16[15:8]);
    foreach (g_words[i]) begin
      for (int b = 0; b < 4; b++) g_img.push_back(8'(g_words[i] >> (8 * b)));
    end
    x = 8'h00;
    foreach (g_img[i]) x = x ^ g_img[i];
    g_img.push_back(x ^ bad);
  endtask

  // mode 0: back-to-back, 1: one gap between bytes, 2: random gaps
  task automatic feed(input int mode, input int max_bytes);
    int lim;
    lim = (max_bytes < g_img.size()) ? max_bytes : g_img.size();
    for (int i = 0; i < lim; i++) begin
      if (mode == 1 && i > 0) cycle(1'b0, 8'($urandom));
      if (mode == 2) begin
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) cycle(1'b0, 8'($urandom));
      end
      cycle(1'b1, g_img[i]);
    end
  endtask

  initial begin
    model_reset();
    do_reset();

    // single word image
    g_words = '{32'h0000_0013};
    build(16'd1, 8'h00);
    check("t1_csum_byte", {24'h0, g_img[6]}, 32'h12);
    feed(0, 1000);
    idle(3);

    // three words with valid toggling
    do_reset();
    g_words = '{32'h0010_0093, 32'h0020_0113, 32'h0020_81B3};
    build(16'd3, 8'h00);
    feed(1, 1000);
    idle(3);

    // empty image
    do_reset();
    g_words.delete();
    build(16'd0, 8'h00);
    feed(0, 1000);
    idle(3);

    // bad checksum, then extra bytes must be ignored
    do_reset();
    g_words = '{32'h0000_0013};
    build(16'd1, 8'h00);
    g_img[6] = 8'hFF;
    for (int i = 0; i < 4; i++) g_img.push_back(8'($urandom));
    feed(2, 1000);
    idle(3);

    // oversize word count
    do_reset();
    g_words = '{32'hDEAD_BEEF, 32'h1234_5678};
    build(16'h0401, 8'h00);
    feed(0, 1000);
    idle(3);

    // reset after two data bytes, then a clean image
    do_reset();
    g_words = '{32'h0000_0013};
    build(16'd1, 8'h00);
    feed(0, 4);
    do_reset();
    feed(0, 1000);
    idle(2);
    @(negedge clk);
    i_core_addr = WIDTH'(12'h010);
    i_core_data = 32'hCAFE_F00D;
    i_core_we   = 1'b1;
    #1;
    check("t6_we", {31'h0, o_mem_we}, 32'h1);
    check("t6_addr", {20'h0, o_mem_addr}, 32'h010);
    check("t6_data", o_mem_data, 32'hCAFE_F00D);

    // exactly full capacity
    do_reset();
    g_words.delete();
    for (int i = 0; i < CAP; i++) g_words.push_back($urandom);
    build(16'(CAP), 8'h00);
    feed(0, 10000);
    idle(3);

    // random images, some corrupt, some interrupted by reset
    for (int t = 0; t < 24; t++) begin
      int n;
      logic [7:0] bad;
      do_reset();
      n = $urandom_range(0, 6);
      g_words.delete();
      for (int i = 0; i < n; i++) g_words.push_back($urandom);
      bad = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      build(16'(n), bad);
      if ($urandom_range(0, 3) == 0) begin
        feed(2, $urandom_range(1, g_img.size()));
        do_reset();
      end
      feed($urandom_range(0, 2), 1000);
      idle($urandom_range(2, 4));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
